// File: rtl/m_ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
`ifndef IMEM_D_DELAY
`define IMEM_D_DELAY 3
`endif

package m_ifetch_pkg;

   // Fetch controller states
   typedef enum logic [1:0] {
      ST_SETTLE = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_IDLE   = 2'd3
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   // Tied to the imem delay define so fetch timing and memory timing cannot drift apart
   localparam int          MEM_LAT_DEF  = `IMEM_D_DELAY;
   localparam int          ENTRY_W      = 64;

   // Force a fetch address onto a word boundary
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return pc & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/m_ifetch_fifo.sv
// Shift-style {pc, insn} buffer: the head is always entry 0 and unused entries are
// kept at zero, so the head reads zero whenever the buffer is empty.
module m_ifetch_fifo
   import m_ifetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   input  logic               push_i,
   input  logic               pop_i,
   input  logic [ENTRY_W-1:0] data_i,
   output logic [ENTRY_W-1:0] head_o,
   output logic [CW-1:0]      count_o
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [ENTRY_W-1:0] mem_d [DEPTH];
   logic [CW-1:0]      cnt_q;
   logic [CW-1:0]      cnt_d;
   logic [CW-1:0]      wr_idx_s;
   logic               pop_s;

   // Next buffer contents: flush wins, otherwise shift on pop then append on push
   always_comb begin
      mem_d    = mem_q;
      cnt_d    = cnt_q;
      wr_idx_s = cnt_q;
      pop_s    = pop_i && (cnt_q != '0);
      if (flush_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = 64'h0;
         end
         cnt_d = '0;
      end else begin
         if (pop_s) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
               mem_d[i] = mem_q[i+1];
            end
            mem_d[DEPTH-1] = 64'h0;
            wr_idx_s       = cnt_q - ONE_C;
         end else begin
            wr_idx_s = cnt_q;
         end
         if (push_i && (wr_idx_s < DEPTH_C)) begin
            mem_d[wr_idx_s] = data_i;
            cnt_d           = wr_idx_s + ONE_C;
         end else begin
            cnt_d = wr_idx_s;
         end
      end
   end

   // Buffer storage and occupancy register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 64'h0;
         end
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         cnt_q <= cnt_d;
      end
   end

   assign head_o  = mem_q[0];
   assign count_o = cnt_q;

endmodule

// File: rtl/m_ifetch.sv
// Instruction fetch stage: one outstanding imem request, a small {pc, insn}
// buffer toward decode, and discard of responses made stale by a redirect.
module m_ifetch
   import m_ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          MEM_LAT  = MEM_LAT_DEF,
   parameter int          DEPTH    = 2
) (
   input  logic        w_clk,
   input  logic        w_rst,
   input  logic        w_redirect,
   input  logic [31:0] w_redirect_pc,
   output logic [31:0] r_imem_pc,
   output logic        r_imem_re,
   input  logic [31:0] w_imem_insn,
   input  logic        w_imem_oe,
   output logic [31:0] r_insn,
   output logic [31:0] r_insn_pc,
   output logic        r_valid,
   input  logic        w_ready
);

   localparam int            CW          = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C       = CW'(1);
   localparam logic [7:0]    SETTLE_LAST = 8'(MEM_LAT);

   fetch_state_e  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic          stale_q, stale_d;
   logic [7:0]    settle_q, settle_d;
   logic          imem_re_q;
   logic [31:0]   imem_pc_q;

   logic          push_s;
   logic          pop_s;
   logic [CW-1:0] cnt_s;
   logic [CW-1:0] cnt_post_s;
   logic [63:0]   head_s;

   // Decode never pops during a redirect; only fresh responses are pushed
   assign pop_s  = (cnt_s != '0) && w_ready && !w_redirect;
   assign push_s = (state_q == ST_WAIT) && w_imem_oe && !stale_q && !w_redirect;

   // Occupancy after this cycle's push/pop/flush, used for the issue decision
   always_comb begin
      cnt_post_s = cnt_s;
      if (w_redirect) begin
         cnt_post_s = '0;
      end else if (push_s && !pop_s) begin
         cnt_post_s = cnt_s + ONE_C;
      end else if (pop_s && !push_s) begin
         cnt_post_s = cnt_s - ONE_C;
      end else begin
         cnt_post_s = cnt_s;
      end
   end

   // Fetch FSM next state, PC and stale-response tracking
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      stale_d  = stale_q;
      settle_d = settle_q;
      case (state_q)
         ST_SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               state_d  = ST_ISSUE;
               settle_d = 8'd0;
            end else begin
               settle_d = settle_q + 8'd1;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (w_imem_oe) begin
               if (stale_q) begin
                  stale_d = 1'b0;
               end else begin
                  pc_d = pc_q + 32'd4;
               end
               state_d = (cnt_post_s < DEPTH_C) ? ST_ISSUE : ST_IDLE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_IDLE: begin
            if (cnt_post_s < DEPTH_C) begin
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_SETTLE;
      endcase
      // A redirect retargets the PC; an outstanding request becomes stale
      if (w_redirect) begin
         pc_d = align_pc(w_redirect_pc);
         case (state_q)
            ST_ISSUE: stale_d = 1'b1;
            ST_WAIT: begin
               if (w_imem_oe) begin
                  stale_d = 1'b0;
                  state_d = ST_ISSUE;
               end else begin
                  stale_d = 1'b1;
               end
            end
            ST_IDLE: state_d = ST_ISSUE;
            default: stale_d = stale_q;
         endcase
      end else begin
         pc_d = pc_d;
      end
   end

   // State, PC and registered imem request outputs
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         state_q   <= ST_SETTLE;
         pc_q      <= RESET_PC;
         stale_q   <= 1'b0;
         settle_q  <= 8'd0;
         imem_re_q <= 1'b0;
         imem_pc_q <= RESET_PC;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         stale_q   <= stale_d;
         settle_q  <= settle_d;
         imem_re_q <= (state_d == ST_ISSUE);
         if (state_d == ST_ISSUE) begin
            imem_pc_q <= pc_d;
         end else begin
            imem_pc_q <= imem_pc_q;
         end
      end
   end

   m_ifetch_fifo #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk_i   (w_clk),
      .rst_i   (w_rst),
      .flush_i (w_redirect),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .data_i  ({pc_q, w_imem_insn}),
      .head_o  (head_s),
      .count_o (cnt_s)
   );

   assign r_imem_pc = imem_pc_q;
   assign r_imem_re = imem_re_q;
   assign r_insn    = head_s[31:0];
   assign r_insn_pc = head_s[63:32];
   assign r_valid   = (cnt_s != '0);

endmodule

// File: tb/tb_m_ifetch.sv
// Directed bench for m_ifetch with a 3-cycle imem model (request c0, data c2).
module tb_m_ifetch;

   logic        w_clk = 1'b0;
   logic        w_rst = 1'b1;
   logic        w_redirect = 1'b0;
   logic [31:0] w_redirect_pc = 32'h0;
   logic [31:0] r_imem_pc;
   logic        r_imem_re;
   logic [31:0] w_imem_insn = 32'h0;
   logic        w_imem_oe = 1'b0;
   logic [31:0] r_insn;
   logic [31:0] r_insn_pc;
   logic        r_valid;
   logic        w_ready = 1'b1;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic        mem_v1 = 1'b0;
   logic [31:0] mem_a1 = 32'h0;

   m_ifetch dut (
      .w_clk         (w_clk),
      .w_rst         (w_rst),
      .w_redirect    (w_redirect),
      .w_redirect_pc (w_redirect_pc),
      .r_imem_pc     (r_imem_pc),
      .r_imem_re     (r_imem_re),
      .w_imem_insn   (w_imem_insn),
      .w_imem_oe     (w_imem_oe),
      .r_insn        (r_insn),
      .r_insn_pc     (r_insn_pc),
      .r_valid       (r_valid),
      .w_ready       (w_ready)
   );

   always #5 w_clk = ~w_clk;

   always @(posedge w_clk) cyc <= cyc + 1;

   // Memory contents: the four preloaded words, a distinct pattern elsewhere
   function automatic logic [31:0] exp_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0000_0013;
         32'h0000_0004: return 32'h0010_0093;
         32'h0000_0008: return 32'h0020_0113;
         32'h0000_000C: return 32'h0030_0193;
         default:       return 32'hA500_0000 ^ a;
      endcase
   endfunction

   // imem model: no reset, data pulse two cycles after the request cycle
   always @(posedge w_clk) begin
      mem_v1      <= r_imem_re;
      mem_a1      <= r_imem_pc;
      w_imem_oe   <= mem_v1;
      w_imem_insn <= mem_v1 ? exp_word(mem_a1) : 32'hDEAD_BEEF;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic reset_dut();
      @(negedge w_clk);
      w_rst = 1'b1;
      repeat (2) @(negedge w_clk);
      w_rst = 1'b0;
   endtask

   // Wait (bounded) for an imem request, checking the current negedge first
   task automatic wait_re(input string tag);
      int n = 0;
      while (!r_imem_re && n < 60) begin
         @(negedge w_clk);
         n++;
      end
      check({tag, "_re"}, {31'd0, r_imem_re}, 32'd1);
   endtask

   // Wait (bounded) for the next instruction accepted by decode and check it
   task automatic expect_insn(input string tag, input logic [31:0] pc_e, output int at);
      int   n   = 0;
      logic got = 1'b0;
      at = -1;
      while (!got && n < 60) begin
         @(negedge w_clk);
         n++;
         if (r_valid && w_ready) begin
            got = 1'b1;
            at  = cyc;
            check({tag, "_pc"}, r_insn_pc, pc_e);
            check({tag, "_insn"}, r_insn, exp_word(pc_e));
         end
      end
      if (!got) check({tag, "_tmo"}, 32'd0, 32'd1);
   endtask

   initial begin
      int t0, t1, t2, t3, tr, n_re;
      logic [31:0] pcs [4];
      pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8; pcs[3] = 32'hC;

      // Reset state
      repeat (2) @(negedge w_clk);
      check("rst_valid", {31'd0, r_valid}, 32'd0);
      check("rst_re", {31'd0, r_imem_re}, 32'd0);
      check("rst_imem_pc", r_imem_pc, 32'h0);
      check("rst_insn", r_insn, 32'h0);
      check("rst_insn_pc", r_insn_pc, 32'h0);
      w_rst = 1'b0;

      // Settle window: first request after MEM_LAT+1 edges
      for (int k = 1; k <= 4; k++) begin
         @(negedge w_clk);
         check($sformatf("settle_re%0d", k), {31'd0, r_imem_re}, (k == 4) ? 32'd1 : 32'd0);
      end
      check("first_imem_pc", r_imem_pc, 32'h0);

      // Straight-line fetch, one instruction every 3 cycles
      expect_insn("seq0", pcs[0], t0);
      expect_insn("seq1", pcs[1], t1);
      expect_insn("seq2", pcs[2], t2);
      expect_insn("seq3", pcs[3], t3);
      check("gap01", 32'(t1 - t0), 32'd3);
      check("gap12", 32'(t2 - t1), 32'd3);
      check("gap23", 32'(t3 - t2), 32'd3);

      // Back-pressure: buffer fills to two, fetch stops
      @(negedge w_clk);
      w_ready = 1'b0;
      repeat (10) @(negedge w_clk);
      n_re = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge w_clk);
         if (r_imem_re) n_re++;
      end
      check("bp_no_re", 32'(n_re), 32'd0);
      check("bp_valid", {31'd0, r_valid}, 32'd1);
      check("bp_head_pc", r_insn_pc, 32'h10);
      check("bp_head_insn", r_insn, exp_word(32'h10));
      w_ready = 1'b1;
      t0 = cyc;
      expect_insn("bp_2nd", 32'h14, t1);
      check("bp_drain_gap", 32'(t1 - t0), 32'd1);
      expect_insn("bp_resume", 32'h18, t2);

      // Redirect while pc 8 is in flight (cycle after ISSUE)
      reset_dut();
      expect_insn("r1_a", 32'h0, t0);
      expect_insn("r1_b", 32'h4, t1);
      wait_re("r1_issue8");
      check("r1_inflight_pc", r_imem_pc, 32'h8);
      @(negedge w_clk);
      w_redirect    = 1'b1;
      w_redirect_pc = 32'h40;
      @(negedge w_clk);
      w_redirect = 1'b0;
      check("r1_valid_after", {31'd0, r_valid}, 32'd0);
      expect_insn("r1_tgt", 32'h40, t0);
      expect_insn("r1_next", 32'h44, t1);

      // Redirect coincident with the response
      wait_re("r2_issue");
      check("r2_issue_pc", r_imem_pc, 32'h48);
      repeat (2) @(negedge w_clk);
      check("r2_oe_now", {31'd0, w_imem_oe}, 32'd1);
      w_redirect    = 1'b1;
      w_redirect_pc = 32'h100;
      @(negedge w_clk);
      w_redirect = 1'b0;
      check("r2_re", {31'd0, r_imem_re}, 32'd1);
      check("r2_imem_pc", r_imem_pc, 32'h100);
      check("r2_valid", {31'd0, r_valid}, 32'd0);
      tr = cyc;
      expect_insn("r2_tgt", 32'h100, t0);
      check("r2_latency", 32'(t0 - tr), 32'd3);

      // Reset with a request in flight: late response must be ignored
      wait_re("rs_issue");
      check("rs_issue_pc", r_imem_pc, 32'h104);
      @(negedge w_clk);
      w_rst = 1'b1;
      @(negedge w_clk);
      w_rst = 1'b0;
      check("rs_valid", {31'd0, r_valid}, 32'd0);
      expect_insn("rs_first", 32'h0, t0);

      // Unaligned redirect near the top of memory, then wrap
      w_redirect    = 1'b1;
      w_redirect_pc = 32'hFFFF_FFFE;
      @(negedge w_clk);
      w_redirect = 1'b0;
      wait_re("wrap_issue");
      check("wrap_imem_pc", r_imem_pc, 32'hFFFF_FFFC);
      expect_insn("wrap_top", 32'hFFFF_FFFC, t0);
      expect_insn("wrap_zero", 32'h0, t1);

      // Back-to-back redirects: the later target wins
      w_redirect    = 1'b1;
      w_redirect_pc = 32'h200;
      @(negedge w_clk);
      w_redirect_pc = 32'h300;
      @(negedge w_clk);
      w_redirect = 1'b0;
      expect_insn("b2b", 32'h300, t0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
